// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 init sequencer shared constants, state and error encodings (PS2_SEQ_WHEEL_EN adds WAIT_ID)
package ps2_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] CMD_RATE  = 8'hF3;
    localparam logic [7:0] CMD_RES   = 8'hE8;
    localparam logic [7:0] CMD_ID    = 8'hF2;
    localparam logic [7:0] CMD_EN    = 8'hF4;

    // Mouse-to-host response bytes
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] ID_WHEEL   = 8'h03;

    // Wide enough for the longest (wheel) command table of 13 steps
    localparam int STEP_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_BAT0,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
`ifdef PS2_SEQ_WHEEL_EN
        , ST_WAIT_ID
`endif
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_RETRY   = 3'd1,
        ERR_FC      = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_BAT     = 3'd4
    } err_code_e;

endpackage

// File: rtl/ps2_cmd_rom.sv
// rtl/ps2_cmd_rom.sv - step index to command byte and reply expectations (PS2_SEQ_WHEEL_EN selects wheel table)
module ps2_cmd_rom
    import ps2_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter logic [7:0] RESOLUTION  = 8'd2
) (
    input  logic [STEP_W-1:0] step,
    output logic [7:0]        cmd_byte,
    output logic              is_last,
    output logic              expect_bat
`ifdef PS2_SEQ_WHEEL_EN
    ,
    output logic              expect_id
`endif
);

`ifdef PS2_SEQ_WHEEL_EN
    // Wheel unlock knock (rate 200,100,80) and ID query sit between reset and the base table
    always_comb begin
        cmd_byte   = 8'h00;
        is_last    = 1'b0;
        expect_bat = 1'b0;
        expect_id  = 1'b0;
        case (step)
            4'd0:  begin cmd_byte = CMD_RESET; expect_bat = 1'b1; end
            4'd1:  cmd_byte = CMD_RATE;
            4'd2:  cmd_byte = 8'hC8;
            4'd3:  cmd_byte = CMD_RATE;
            4'd4:  cmd_byte = 8'h64;
            4'd5:  cmd_byte = CMD_RATE;
            4'd6:  cmd_byte = 8'h50;
            4'd7:  begin cmd_byte = CMD_ID; expect_id = 1'b1; end
            4'd8:  cmd_byte = CMD_RATE;
            4'd9:  cmd_byte = SAMPLE_RATE;
            4'd10: cmd_byte = CMD_RES;
            4'd11: cmd_byte = RESOLUTION;
            4'd12: begin cmd_byte = CMD_EN; is_last = 1'b1; end
            default: ;
        endcase
    end
`else
    // Base table: reset, sample rate, resolution, enable reporting
    always_comb begin
        cmd_byte   = 8'h00;
        is_last    = 1'b0;
        expect_bat = 1'b0;
        case (step)
            4'd0: begin cmd_byte = CMD_RESET; expect_bat = 1'b1; end
            4'd1: cmd_byte = CMD_RATE;
            4'd2: cmd_byte = SAMPLE_RATE;
            4'd3: cmd_byte = CMD_RES;
            4'd4: cmd_byte = RESOLUTION;
            4'd5: begin cmd_byte = CMD_EN; is_last = 1'b1; end
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/ps2_init_sequencer.sv
// rtl/ps2_init_sequencer.sv - PS/2 mouse init command sequencer and stream forwarder (PS2_SEQ_WHEEL_EN enables wheel detect)
module ps2_init_sequencer
    import ps2_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [7:0]  RESOLUTION  = 8'd2,
    parameter logic [19:0] ACK_TIMEOUT = 20'd200000,
    parameter logic [23:0] BAT_TIMEOUT = 24'd10000000,
    parameter logic [1:0]  MAX_RETRIES = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       ready,
    output logic       busy,
    output logic       error,
    output logic [2:0] err_code,
    output logic [7:0] stream_byte,
    output logic       stream_valid,
    output logic       wheel_mode
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        retry_q, retry_d;
    logic [23:0]       timer_q, timer_d;
    err_code_e         err_q, err_d;
    logic              wheel_q, wheel_d;
    logic [7:0]        stream_byte_q, stream_byte_d;
    logic              stream_valid_q, stream_valid_d;

    logic [7:0]        rom_byte;
    logic              rom_last;
    logic              rom_bat;
`ifdef PS2_SEQ_WHEEL_EN
    logic              rom_id;
`endif

    logic [23:0]       timer_inc;
    logic              ack_expired;
    logic              bat_expired;

    ps2_cmd_rom #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .RESOLUTION  (RESOLUTION)
    ) u_rom (
        .step       (step_q),
        .cmd_byte   (rom_byte),
        .is_last    (rom_last),
        .expect_bat (rom_bat)
`ifdef PS2_SEQ_WHEEL_EN
        ,
        .expect_id  (rom_id)
`endif
    );

    // Expiry fires on the wait cycle whose increment reaches the limit
    assign timer_inc   = timer_q + 24'd1;
    assign ack_expired = timer_inc >= {4'd0, ACK_TIMEOUT};
    assign bat_expired = timer_inc >= BAT_TIMEOUT;

    // Next-state, step/retry bookkeeping, timeouts and stream forwarding
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        retry_d        = retry_q;
        timer_d        = timer_q;
        err_d          = err_q;
        wheel_d        = wheel_q;
        stream_valid_d = 1'b0;
        stream_byte_d  = stream_byte_q;
        if (start) begin
            state_d = ST_SEND;
            step_d  = '0;
            retry_d = '0;
            timer_d = '0;
            err_d   = ERR_NONE;
            wheel_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SEND: begin
                    timer_d = '0;
                    state_d = ST_WAIT_TX;
                end
                // Bytes arriving before the tx engine finishes cannot be replies to this command
                ST_WAIT_TX: begin
                    timer_d = timer_inc;
                    if (tx_done) begin
                        state_d = ST_WAIT_ACK;
                    end else if (ack_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_WAIT_ACK: begin
                    timer_d = timer_inc;
                    if (rx_valid && rx_byte == RSP_ACK) begin
                        timer_d = '0;
                        if (rom_bat) begin
                            state_d = ST_WAIT_BAT;
`ifdef PS2_SEQ_WHEEL_EN
                        end else if (rom_id) begin
                            state_d = ST_WAIT_ID;
`endif
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if (rx_valid && rx_byte == RSP_RESEND) begin
                        if (retry_q == MAX_RETRIES) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_RETRY;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_SEND;
                        end
                    end else if (rx_valid && rx_byte == RSP_ERROR) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_FC;
                    end else if (ack_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_WAIT_BAT: begin
                    timer_d = timer_inc;
                    if (rx_valid) begin
                        if (rx_byte == RSP_BAT_OK) begin
                            timer_d = '0;
                            state_d = ST_WAIT_BAT0;
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = ERR_BAT;
                        end
                    end else if (bat_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                // Device ID after BAT is normally 00; its value is not checked
                ST_WAIT_BAT0: begin
                    timer_d = timer_inc;
                    if (rx_valid) begin
                        state_d = ST_NEXT;
                    end else if (bat_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
`ifdef PS2_SEQ_WHEEL_EN
                ST_WAIT_ID: begin
                    timer_d = timer_inc;
                    if (rx_valid) begin
                        wheel_d = (rx_byte == ID_WHEEL);
                        state_d = ST_NEXT;
                    end else if (ack_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
`endif
                ST_NEXT: begin
                    retry_d = '0;
                    timer_d = '0;
                    if (rom_last) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_SEND;
                    end
                end
                ST_DONE: begin
                    if (rx_valid) begin
                        stream_valid_d = 1'b1;
                        stream_byte_d  = rx_byte;
                    end
                end
                ST_ERROR: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            step_q         <= '0;
            retry_q        <= '0;
            timer_q        <= '0;
            err_q          <= ERR_NONE;
            wheel_q        <= 1'b0;
            stream_byte_q  <= 8'h00;
            stream_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            err_q          <= err_d;
            wheel_q        <= wheel_d;
            stream_byte_q  <= stream_byte_d;
            stream_valid_q <= stream_valid_d;
        end
    end

    assign tx_req       = (state_q == ST_SEND);
    assign tx_byte      = tx_req ? rom_byte : 8'h00;
    assign ready        = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign busy         = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign err_code     = err_q;
    assign stream_byte  = stream_byte_q;
    assign stream_valid = stream_valid_q;
    assign wheel_mode   = wheel_q;

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// tb/tb_ps2_init_sequencer.sv - directed self-checking bench for ps2_init_sequencer (PS2_SEQ_WHEEL_EN aware)
module tb_ps2_init_sequencer;

    localparam int ACK_TO = 200;
    localparam int BAT_TO = 300;
`ifdef PS2_SEQ_WHEEL_EN
    localparam logic EXP_WHEEL_03 = 1'b1;
`else
    localparam logic EXP_WHEEL_03 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ready;
    logic       busy;
    logic       error;
    logic [2:0] err_code;
    logic [7:0] stream_byte;
    logic       stream_valid;
    logic       wheel_mode;

    int checks = 0;
    int errors = 0;
    int tx_cnt = 0;
    int snap;
    logic [7:0] sb [3];

    ps2_init_sequencer #(
        .SAMPLE_RATE (8'd100),
        .RESOLUTION  (8'd2),
        .ACK_TIMEOUT (20'(ACK_TO)),
        .BAT_TIMEOUT (24'(BAT_TO)),
        .MAX_RETRIES (2'd3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tx_req       (tx_req),
        .tx_byte      (tx_byte),
        .tx_done      (tx_done),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .ready        (ready),
        .busy         (busy),
        .error        (error),
        .err_code     (err_code),
        .stream_byte  (stream_byte),
        .stream_valid (stream_valid),
        .wheel_mode   (wheel_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_req) tx_cnt <= tx_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("error_after_start", error, 0);
    endtask

    task automatic rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!tx_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, tx_req, 1);
        check_eq(tag, tx_byte, exp);
    endtask

    task automatic cmd_noreply(input string tag, input logic [7:0] exp);
        wait_tx(tag, exp);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic cmd(input string tag, input logic [7:0] exp, input logic [7:0] reply);
        cmd_noreply(tag, exp);
        rx(reply);
    endtask

    task automatic boot(input logic [7:0] id);
        pulse_start();
        cmd("ff", 8'hFF, 8'hFA);
        rx(8'hAA);
        rx(8'h00);
`ifdef PS2_SEQ_WHEEL_EN
        cmd("knock_f3a", 8'hF3, 8'hFA);
        cmd("knock_c8",  8'hC8, 8'hFA);
        cmd("knock_f3b", 8'hF3, 8'hFA);
        cmd("knock_64",  8'h64, 8'hFA);
        cmd("knock_f3c", 8'hF3, 8'hFA);
        cmd("knock_50",  8'h50, 8'hFA);
        cmd("get_id",    8'hF2, 8'hFA);
        rx(id);
`else
        if (id != 8'h00) rx_byte = 8'h00;
`endif
    endtask

    task automatic tail_from_rate();
        cmd("rate_cmd", 8'hF3, 8'hFA);
        cmd("rate_val", 8'h64, 8'hFA);
        cmd("res_cmd",  8'hE8, 8'hFA);
        cmd("res_val",  8'h02, 8'hFA);
        cmd("enable",   8'hF4, 8'hFA);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        sb[0] = 8'h08;
        sb[1] = 8'h05;
        sb[2] = 8'hFB;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_tx_req", tx_req, 0);
        check_eq("rst_stream_valid", stream_valid, 0);
        check_eq("rst_wheel", wheel_mode, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", busy, 0);

        // T1/T6: full init, every byte acked
        boot(8'h03);
        tail_from_rate();
        check_eq("t1_ready", ready, 1);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_err_code", err_code, 0);
        check_eq("t1_wheel", wheel_mode, EXP_WHEEL_03);

        // T5b: streaming with one cycle latency
        foreach (sb[i]) begin
            rx_byte  = sb[i];
            rx_valid = 1'b1;
            check_eq("t5b_sv_before", stream_valid, 0);
            @(negedge clk);
            rx_valid = 1'b0;
            check_eq("t5b_sv", stream_valid, 1);
            check_eq("t5b_sbyte", stream_byte, sb[i]);
            @(negedge clk);
            check_eq("t5b_sv_after", stream_valid, 0);
        end

        // T2: three FE then FA completes; four FE exhausts retries
        boot(8'h03);
        repeat (3) cmd("t2_f3_retry", 8'hF3, 8'hFE);
        tail_from_rate();
        check_eq("t2_ready", ready, 1);
        boot(8'h03);
        repeat (4) cmd("t2b_f3_retry", 8'hF3, 8'hFE);
        repeat (2) @(negedge clk);
        check_eq("t2b_error", error, 1);
        check_eq("t2b_err_code", err_code, 1);
        check_eq("t2b_ready", ready, 0);
        check_eq("t2b_busy", busy, 0);

        // T3: FC to E8 stops the sequence
        boot(8'h03);
        cmd("t3_rate_cmd", 8'hF3, 8'hFA);
        cmd("t3_rate_val", 8'h64, 8'hFA);
        cmd("t3_res_cmd", 8'hE8, 8'hFC);
        repeat (2) @(negedge clk);
        check_eq("t3_error", error, 1);
        check_eq("t3_err_code", err_code, 2);
        snap = tx_cnt;
        repeat (30) @(negedge clk);
        check_eq("t3_no_tx", tx_cnt, snap);

        // T4: ack timeout boundary, then restart resends FF
        pulse_start();
        cmd_noreply("t4_ff", 8'hFF);
        repeat (ACK_TO - 10) @(negedge clk);
        check_eq("t4_error_early", error, 0);
        repeat (20) @(negedge clk);
        check_eq("t4_error", error, 1);
        check_eq("t4_err_code", err_code, 3);
        pulse_start();
        check_eq("t4_err_code_clr", err_code, 0);
        wait_tx("t4_ff_again", 8'hFF);

        // T5: bad BAT byte
        pulse_start();
        cmd("t5_ff", 8'hFF, 8'hFA);
        rx(8'hFC);
        repeat (2) @(negedge clk);
        check_eq("t5_err_code", err_code, 4);

        // BAT timeout boundary
        pulse_start();
        cmd("bt_ff", 8'hFF, 8'hFA);
        repeat (BAT_TO - 10) @(negedge clk);
        check_eq("bt_error_early", error, 0);
        repeat (20) @(negedge clk);
        check_eq("bt_err_code", err_code, 3);

        // tx_done with rx_valid in WAIT_TX drops the byte
        pulse_start();
        wait_tx("t7_ff", 8'hFF);
        @(negedge clk);
        tx_done  = 1'b1;
        rx_byte  = 8'hFA;
        rx_valid = 1'b1;
        @(negedge clk);
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        snap = tx_cnt;
        repeat (5) @(negedge clk);
        check_eq("t7_still_busy", busy, 1);
        check_eq("t7_no_tx", tx_cnt, snap);
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_tx("t7_next", 8'hF3);

        // T6b: restart mid-sequence, ID 00 leaves wheel_mode clear
        boot(8'h00);
        tail_from_rate();
        check_eq("t6b_ready", ready, 1);
        check_eq("t6b_wheel", wheel_mode, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
